// File: rtl/ex_bitpack.sv
// Streaming bit-field packer: deposits 1..32-bit fields into 32-bit words.
// Define EX_BITPACK_MSB_FIRST_EN to fill words from bit 31 downward instead of bit 0 upward.
module ex_bitpack #(
    parameter int WORD_W = 32,
    parameter int SIZE_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic [SIZE_W-1:0] in_size,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic [5:0]        out_bits,
    output logic              out_last
);

    logic [63:0] r_acc;
    logic [6:0]  r_cnt;
    logic        r_flush_pend;

    logic [6:0]  w_width;
    logic [31:0] w_mask;
    logic [63:0] w_masked;
    logic [63:0] w_field_pos;
    logic [63:0] w_acc_shift;
    logic        w_in_fire;
    logic        w_out_fire;

    assign w_width  = 7'(in_size) + 7'd1;
    // Shifting all-ones right keeps width-32 fields fully unmasked without a 33-bit term.
    assign w_mask   = 32'hFFFF_FFFF >> (5'd31 - 5'(in_size));
    assign w_masked = {32'd0, in_data & w_mask};

`ifdef EX_BITPACK_MSB_FIRST_EN
    // Current word lives in acc[63:32]; a field's MSB lands at bit 63-cnt.
    assign w_field_pos = w_masked << (7'd64 - r_cnt - w_width);
    assign w_acc_shift = r_acc << 32;
    assign out_data    = r_acc[63:32];
`else
    assign w_field_pos = w_masked << r_cnt;
    assign w_acc_shift = r_acc >> 32;
    assign out_data    = r_acc[31:0];
`endif

    assign in_ready   = (r_cnt < 7'd32) && !r_flush_pend;
    assign out_valid  = (r_cnt >= 7'd32) || (r_flush_pend && (r_cnt != 7'd0));
    assign out_bits   = (r_cnt >= 7'd32) ? 6'd32 : r_cnt[5:0];
    assign out_last   = r_flush_pend && (r_cnt <= 7'd32);
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;

    // in_ready and out_valid are mutually exclusive, so at most one branch fires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc        <= 64'd0;
            r_cnt        <= 7'd0;
            r_flush_pend <= 1'b0;
        end else if (w_in_fire) begin
            r_acc        <= r_acc | w_field_pos;
            r_cnt        <= r_cnt + w_width;
            r_flush_pend <= r_flush_pend | in_last;
        end else if (w_out_fire) begin
            r_acc <= w_acc_shift;
            r_cnt <= r_cnt - {1'b0, out_bits};
            if (out_last) begin
                r_flush_pend <= 1'b0;
            end
        end
    end

endmodule
